// File: rtl/wqe_dispatcher.sv
// wqe_dispatcher
// Accepts one work-queue element at a time, decodes it and either issues a
// single DMA read and waits for its completion status, or commits it straight
// away. Every WQE finishes with exactly one completion (commit) carrying the
// slot id and an error flag. Statistics counters track commits and errors.
//
// Ports
//   clk, rst                     clock, asynchronous active-high reset
//   s_axis_wqe_*                 WQE input stream (data, qpn, id, valid/ready)
//   m_axis_dma_req_*             DMA read request (addr, len, tag, valid/ready)
//   s_axis_dma_status_*          DMA completion strobe (tag, error, valid)
//   m_axis_cq_*                  completion commit (id, error, valid/ready)
//   enable                       gates acceptance of new WQEs
//   stat_wqe_count/err_count     saturating commit / error-commit counters
module wqe_dispatcher #(
    parameter int QUEUE_INDEX_WIDTH = 10,
    parameter int QUEUE_RAM_AWIDTH  = 10,
    parameter int TAG_WIDTH         = 8,
    parameter int TIMEOUT_CYCLES    = 4096
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [255:0]                 s_axis_wqe_data,
    input  logic [QUEUE_INDEX_WIDTH-1:0] s_axis_wqe_qpn,
    input  logic [QUEUE_RAM_AWIDTH-1:0]  s_axis_wqe_id,
    input  logic                         s_axis_wqe_valid,
    output logic                         s_axis_wqe_ready,
    output logic [63:0]                  m_axis_dma_req_addr,
    output logic [15:0]                  m_axis_dma_req_len,
    output logic [TAG_WIDTH-1:0]         m_axis_dma_req_tag,
    output logic                         m_axis_dma_req_valid,
    input  logic                         m_axis_dma_req_ready,
    input  logic [TAG_WIDTH-1:0]         s_axis_dma_status_tag,
    input  logic                         s_axis_dma_status_error,
    input  logic                         s_axis_dma_status_valid,
    output logic [QUEUE_RAM_AWIDTH-1:0]  m_axis_cq_id,
    output logic                         m_axis_cq_error,
    output logic                         m_axis_cq_valid,
    input  logic                         m_axis_cq_ready,
    input  logic                         enable,
    output logic [31:0]                  stat_wqe_count,
    output logic [31:0]                  stat_err_count
);

    localparam int TIMER_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

    state_t state_reg, state_next;

    logic [63:0]                  addr_reg;
    logic [15:0]                  len_reg;
    logic [7:0]                   opcode_reg;
    logic [QUEUE_INDEX_WIDTH-1:0] qpn_reg;
    logic [QUEUE_RAM_AWIDTH-1:0]  id_reg;
    logic [TAG_WIDTH-1:0]         tag_reg;
    logic [TAG_WIDTH-1:0]         wait_tag_reg;
    logic [TIMER_W-1:0]           timer_reg;
    logic                         err_reg;
    logic [31:0]                  wqe_cnt_reg;
    logic [31:0]                  err_cnt_reg;

    // Field decode of the incoming WQE body
    logic [63:0] wqe_addr;
    logic [15:0] wqe_len;
    logic [7:0]  wqe_op;
    assign wqe_addr = s_axis_wqe_data[63:0];
    assign wqe_len  = s_axis_wqe_data[79:64];
    assign wqe_op   = s_axis_wqe_data[87:80];

    logic go_issue, ok_commit;
    assign go_issue  = (wqe_op == 8'h01) && (wqe_len != 16'd0);
    assign ok_commit = (wqe_op == 8'h00) || ((wqe_op == 8'h01) && (wqe_len == 16'd0));

    logic wqe_fire, dma_fire, status_hit, timeout_hit, cq_fire;
    assign wqe_fire    = s_axis_wqe_valid && s_axis_wqe_ready;
    assign dma_fire    = (state_reg == ST_ISSUE) && m_axis_dma_req_ready;
    assign status_hit  = (state_reg == ST_WAIT) && s_axis_dma_status_valid &&
                         (s_axis_dma_status_tag == wait_tag_reg);
    assign timeout_hit = (state_reg == ST_WAIT) && (timer_reg == TIMER_LAST);
    assign cq_fire     = (state_reg == ST_COMMIT) && m_axis_cq_ready;

    // Fields that are captured but not consumed downstream, plus the
    // reserved part of the WQE body.
    logic unused_bits;
    assign unused_bits = ^{s_axis_wqe_data[255:88], opcode_reg, qpn_reg};

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (wqe_fire) begin
                    state_next = go_issue ? ST_ISSUE : ST_COMMIT;
                end
            end
            ST_ISSUE: begin
                if (dma_fire) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (status_hit || timeout_hit) begin
                    state_next = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                if (cq_fire) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Output logic; ready is forced low while reset is held because the
    // state register already reads IDLE during reset.
    always_comb begin
        s_axis_wqe_ready     = enable && (state_reg == ST_IDLE) && !rst;
        m_axis_dma_req_valid = (state_reg == ST_ISSUE);
        m_axis_cq_valid      = (state_reg == ST_COMMIT);
    end

    assign m_axis_dma_req_addr = addr_reg;
    assign m_axis_dma_req_len  = len_reg;
    assign m_axis_dma_req_tag  = tag_reg;
    assign m_axis_cq_id        = id_reg;
    assign m_axis_cq_error     = err_reg;
    assign stat_wqe_count      = wqe_cnt_reg;
    assign stat_err_count      = err_cnt_reg;

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_reg     <= '0;
            len_reg      <= '0;
            opcode_reg   <= '0;
            qpn_reg      <= '0;
            id_reg       <= '0;
            tag_reg      <= '0;
            wait_tag_reg <= '0;
            timer_reg    <= '0;
            err_reg      <= 1'b0;
            wqe_cnt_reg  <= '0;
            err_cnt_reg  <= '0;
        end else begin
            if (wqe_fire) begin
                addr_reg   <= wqe_addr;
                len_reg    <= wqe_len;
                opcode_reg <= wqe_op;
                qpn_reg    <= s_axis_wqe_qpn;
                id_reg     <= s_axis_wqe_id;
                err_reg    <= !(go_issue || ok_commit);
            end

            // The issued tag is remembered separately so the live tag
            // register can advance right at the request handshake.
            if (dma_fire) begin
                wait_tag_reg <= tag_reg;
                tag_reg      <= tag_reg + 1'b1;
                timer_reg    <= '0;
            end else if (state_reg == ST_WAIT) begin
                timer_reg <= timer_reg + 1'b1;
            end

            // A matching status wins over a simultaneous timeout.
            if (status_hit) begin
                err_reg <= s_axis_dma_status_error;
            end else if (timeout_hit) begin
                err_reg <= 1'b1;
            end

            if (cq_fire) begin
                if (wqe_cnt_reg != 32'hFFFF_FFFF) begin
                    wqe_cnt_reg <= wqe_cnt_reg + 32'd1;
                end
                if (err_reg && (err_cnt_reg != 32'hFFFF_FFFF)) begin
                    err_cnt_reg <= err_cnt_reg + 32'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_wqe_dispatcher.sv
// Directed testbench for wqe_dispatcher. Inputs change on the falling edge,
// outputs are sampled on the falling edge after the handshake edge.
module tb_wqe_dispatcher;

    localparam int T = 16;

    logic         clk;
    logic         rst;
    logic [255:0] wqe_data;
    logic [9:0]   wqe_qpn;
    logic [9:0]   wqe_id;
    logic         wqe_valid;
    logic         wqe_ready;
    logic [63:0]  dma_addr;
    logic [15:0]  dma_len;
    logic [7:0]   dma_tag;
    logic         dma_valid;
    logic         dma_ready;
    logic [7:0]   st_tag;
    logic         st_error;
    logic         st_valid;
    logic [9:0]   cq_id;
    logic         cq_error;
    logic         cq_valid;
    logic         cq_ready;
    logic         enable;
    logic [31:0]  wqe_count;
    logic [31:0]  err_count;

    int total = 0;
    int bad   = 0;

    wqe_dispatcher #(
        .QUEUE_INDEX_WIDTH(10),
        .QUEUE_RAM_AWIDTH (10),
        .TAG_WIDTH        (8),
        .TIMEOUT_CYCLES   (T)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .s_axis_wqe_data        (wqe_data),
        .s_axis_wqe_qpn         (wqe_qpn),
        .s_axis_wqe_id          (wqe_id),
        .s_axis_wqe_valid       (wqe_valid),
        .s_axis_wqe_ready       (wqe_ready),
        .m_axis_dma_req_addr    (dma_addr),
        .m_axis_dma_req_len     (dma_len),
        .m_axis_dma_req_tag     (dma_tag),
        .m_axis_dma_req_valid   (dma_valid),
        .m_axis_dma_req_ready   (dma_ready),
        .s_axis_dma_status_tag  (st_tag),
        .s_axis_dma_status_error(st_error),
        .s_axis_dma_status_valid(st_valid),
        .m_axis_cq_id           (cq_id),
        .m_axis_cq_error        (cq_error),
        .m_axis_cq_valid        (cq_valid),
        .m_axis_cq_ready        (cq_ready),
        .enable                 (enable),
        .stat_wqe_count         (wqe_count),
        .stat_err_count         (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", name, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // All tasks start and end at a falling edge.
    task automatic send_wqe(input logic [7:0] op, input logic [63:0] addr,
                            input logic [15:0] len, input logic [9:0] id);
        wqe_data  = {168'd0, op, len, addr};
        wqe_qpn   = id + 10'd100;
        wqe_id    = id;
        wqe_valid = 1'b1;
        check("wqe_ready", wqe_ready, 1);
        cycle();
        wqe_valid = 1'b0;
        $display("wqe   id=%0d op=0x%02h addr=0x%0h len=%0d", id, op, addr, len);
    endtask

    task automatic dma_accept(input logic [63:0] addr, input logic [15:0] len,
                              input logic [7:0] tag);
        check("dma_valid", dma_valid, 1);
        check("dma_addr", dma_addr, addr);
        check("dma_len", dma_len, len);
        check("dma_tag", dma_tag, tag);
        dma_ready = 1'b1;
        cycle();
        dma_ready = 1'b0;
        check("dma_drop", dma_valid, 0);
        $display("dma   addr=0x%0h len=%0d tag=%0d", addr, len, tag);
    endtask

    task automatic status(input logic [7:0] tag, input logic err);
        st_tag   = tag;
        st_error = err;
        st_valid = 1'b1;
        cycle();
        st_valid = 1'b0;
        $display("stat  tag=%0d err=%0d", tag, err);
    endtask

    task automatic cq_accept(input logic [9:0] id, input logic err);
        check("cq_valid", cq_valid, 1);
        check("cq_id", cq_id, id);
        check("cq_error", cq_error, err);
        cq_ready = 1'b1;
        cycle();
        cq_ready = 1'b0;
        check("cq_drop", cq_valid, 0);
        $display("cq    id=%0d err=%0d", id, err);
    endtask

    task automatic counts(input int w, input int e);
        check("stat_wqe", wqe_count, w);
        check("stat_err", err_count, e);
    endtask

    initial begin
        rst = 1'b1; wqe_data = '0; wqe_qpn = '0; wqe_id = '0; wqe_valid = 1'b0;
        dma_ready = 1'b0; st_tag = '0; st_error = 1'b0; st_valid = 1'b0;
        cq_ready = 1'b0; enable = 1'b1;
        @(negedge clk);
        // reset state
        check("rst_wqe_ready", wqe_ready, 0);
        check("rst_dma_valid", dma_valid, 0);
        check("rst_cq_valid", cq_valid, 0);
        check("rst_dma_tag", dma_tag, 0);
        counts(0, 0);
        cycle();
        rst = 1'b0;
        cycle();

        // SEND
        send_wqe(8'h01, 64'h1000, 16'd64, 10'd5);
        check("send_no_cq", cq_valid, 0);
        dma_accept(64'h1000, 16'd64, 8'd0);
        status(8'd0, 1'b0);
        cq_accept(10'd5, 1'b0);
        counts(1, 0);

        // NOP: commit one cycle after accept, no DMA
        send_wqe(8'h00, 64'hDEAD, 16'd8, 10'd3);
        check("nop_no_dma", dma_valid, 0);
        cq_accept(10'd3, 1'b0);
        counts(2, 0);

        // bad opcode
        send_wqe(8'h7F, 64'h0, 16'd4, 10'd7);
        check("bad_no_dma", dma_valid, 0);
        cq_accept(10'd7, 1'b1);
        counts(3, 1);

        // SEND with zero length commits cleanly without DMA
        send_wqe(8'h01, 64'h3000, 16'd0, 10'd8);
        check("len0_no_dma", dma_valid, 0);
        cq_accept(10'd8, 1'b0);
        counts(4, 1);

        // backpressure on request, mismatched status, backpressure on commit
        send_wqe(8'h01, 64'h2000, 16'd32, 10'd9);
        for (int i = 0; i < 10; i++) begin
            cycle();
            check("bp_dma_valid", dma_valid, 1);
            check("bp_dma_addr", dma_addr, 64'h2000);
            check("bp_dma_tag", dma_tag, 8'd1);
            check("bp_wqe_ready", wqe_ready, 0);
        end
        dma_accept(64'h2000, 16'd32, 8'd1);
        status(8'd5, 1'b0);
        check("mis_cq_valid", cq_valid, 0);
        check("mis_dma_valid", dma_valid, 0);
        status(8'd1, 1'b1);
        for (int i = 0; i < 10; i++) begin
            cycle();
            check("bp_cq_valid", cq_valid, 1);
            check("bp_cq_id", cq_id, 10'd9);
            check("bp_cq_error", cq_error, 1);
            check("bp_cq_wqe_ready", wqe_ready, 0);
        end
        cq_accept(10'd9, 1'b1);
        counts(5, 2);

        // timeout: commit exactly T cycles after the request handshake
        send_wqe(8'h01, 64'h4000, 16'd16, 10'd10);
        dma_accept(64'h4000, 16'd16, 8'd2);
        for (int i = 0; i < T - 1; i++) begin
            cycle();
            check("to_pending", cq_valid, 0);
        end
        cycle();
        cq_accept(10'd10, 1'b1);
        counts(6, 3);

        // matching status coincides with the timeout: status wins
        send_wqe(8'h01, 64'h5000, 16'd16, 10'd11);
        dma_accept(64'h5000, 16'd16, 8'd3);
        for (int i = 0; i < T - 1; i++) begin
            cycle();
        end
        check("same_pending", cq_valid, 0);
        status(8'd3, 1'b0);
        cq_accept(10'd11, 1'b0);
        counts(7, 3);

        // enable low blocks acceptance but lets the in-flight WQE finish
        send_wqe(8'h01, 64'h6000, 16'd8, 10'd12);
        enable = 1'b0;
        dma_accept(64'h6000, 16'd8, 8'd4);
        status(8'd4, 1'b0);
        cq_accept(10'd12, 1'b0);
        check("en_low_ready", wqe_ready, 0);
        enable = 1'b1;
        #1;
        check("en_high_ready", wqe_ready, 1);
        counts(8, 3);

        // reset while waiting for status: no commit afterwards
        send_wqe(8'h01, 64'h7000, 16'd8, 10'd13);
        dma_accept(64'h7000, 16'd8, 8'd5);
        rst = 1'b1;
        #1;
        check("mid_rst_ready", wqe_ready, 0);
        check("mid_rst_dma", dma_valid, 0);
        check("mid_rst_cq", cq_valid, 0);
        check("mid_rst_addr", dma_addr, 0);
        check("mid_rst_tag", dma_tag, 0);
        check("mid_rst_cqid", cq_id, 0);
        counts(0, 0);
        @(negedge clk);
        rst = 1'b0;
        status(8'd5, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("post_rst_cq", cq_valid, 0);
            cycle();
        end
        check("post_rst_ready", wqe_ready, 1);

        // 257 SENDs: tag wraps 255 -> 0
        for (int i = 0; i < 257; i++) begin
            send_wqe(8'h01, 64'h10000 + 64'(i), 16'd4, 10'(i));
            dma_accept(64'h10000 + 64'(i), 16'd4, 8'(i));
            status(8'(i), 1'b0);
            cq_accept(10'(i), 1'b0);
        end
        check("wrap_tag", dma_tag, 8'd1);
        counts(257, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wqe_dispatcher.md
WQE_DISPATCHER -- requirements
Module: wqe_dispatcher

Interface
REQ-001 SHALL have parameter QUEUE_INDEX_WIDTH, default 10, width of the QP number.
REQ-002 SHALL have parameter QUEUE_RAM_AWIDTH, default 10, width of the WQE slot id and the CQ id.
REQ-003 SHALL have parameter TAG_WIDTH, default 8, width of the DMA request tag.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 4096, DMA completion timeout in clk cycles (minimum 2).
REQ-005 Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- s_axis_wqe_data  in  256  WQE body
- s_axis_wqe_qpn  in  QUEUE_INDEX_WIDTH  QP number
- s_axis_wqe_id  in  QUEUE_RAM_AWIDTH  WQE slot id
- s_axis_wqe_valid  in  1  WQE valid
- s_axis_wqe_ready  out  1  WQE accept
- m_axis_dma_req_addr  out  64  DMA read address
- m_axis_dma_req_len  out  16  DMA length in bytes
- m_axis_dma_req_tag  out  TAG_WIDTH  request tag
- m_axis_dma_req_valid  out  1  request valid
- m_axis_dma_req_ready  in  1  request accept
- s_axis_dma_status_tag  in  TAG_WIDTH  completed tag
- s_axis_dma_status_error  in  1  DMA failed
- s_axis_dma_status_valid  in  1  status strobe (no ready)
- m_axis_cq_id  out  QUEUE_RAM_AWIDTH  slot id to commit
- m_axis_cq_error  out  1  completion carries error
- m_axis_cq_valid  out  1  commit valid
- m_axis_cq_ready  in  1  commit accept
- enable  in  1  gates acceptance of new WQEs
- stat_wqe_count  out  32  committed WQEs
- stat_err_count  out  32  commits with error set

Function
REQ-006 SHALL decode WQE fields: addr = data[63:0], len = data[79:64], opcode = data[87:80]; all other bits are ignored.
REQ-007 SHALL implement FSM states IDLE, ISSUE, WAIT, COMMIT; only one WQE SHALL be in flight at a time.
REQ-008 SHALL drive s_axis_wqe_ready = enable AND (state == IDLE), combinationally.
REQ-009 On a WQE handshake, SHALL register addr, len, opcode, qpn and id, then transition as follows:
- opcode 0x01 with len != 0 -> ISSUE
- opcode 0x00, or 0x01 with len == 0 -> COMMIT with error = 0
- any other opcode -> COMMIT with error = 1
REQ-010 In ISSUE, SHALL hold dma_req_valid = 1 with addr, len and tag stable until dma_req_ready is sampled high, then SHALL go to WAIT and clear the timer.
REQ-011 The tag register SHALL increment by 1 after each DMA request handshake and SHALL wrap modulo 2^TAG_WIDTH.
REQ-012 In WAIT, a status with valid = 1 and tag equal to the issued tag SHALL go to COMMIT with error = status_error.
REQ-013 In WAIT, a status whose tag does not match, or any status in another state, SHALL be ignored.
REQ-014 In WAIT, when the timer reaches TIMEOUT_CYCLES-1, SHALL go to COMMIT with error = 1.
REQ-015 If a matching status and the timeout occur in the same cycle, the status SHALL take precedence.
REQ-016 In COMMIT, SHALL drive cq_valid = 1 with cq_id = the registered id and cq_error stable; on cq_ready SHALL return to IDLE.
REQ-017 On each commit handshake, stat_wqe_count SHALL increment, and stat_err_count SHALL also increment when cq_error = 1; both counters SHALL saturate at 0xFFFFFFFF.
REQ-018 Latency: a WQE accepted at edge N SHALL present dma_req_valid or cq_valid after edge N (one cycle).
REQ-019 Latency: a matching status sampled at edge M SHALL present cq_valid after edge M.
REQ-020 Deasserting enable SHALL only block new acceptance; a WQE already in flight SHALL complete normally.

Reset
REQ-021 On rst high, asynchronously and regardless of state: FSM = IDLE; tag, timer and both counters = 0; all valid outputs = 0; all data outputs = 0; s_axis_wqe_ready = 0 while rst is asserted.
REQ-022 Reset asserted mid-operation SHALL discard the in-flight WQE with no commit; a status arriving after reset release SHALL be ignored.

Verification
REQ-023 SEND scenario: WQE opcode 0x01, addr 0x1000, len 64, id 5 -> DMA request addr 0x1000, len 64, tag 0; status tag 0 with error 0 -> cq_id 5, error 0; stat_wqe_count = 1.
REQ-024 NOP scenario: WQE opcode 0x00, id 3 -> no DMA request; cq_id 3, error 0 one cycle after accept. Bad-opcode scenario: WQE opcode 0x7F -> cq error 1; stat_err_count = 1.
REQ-025 Timeout scenario: SEND issued, no status for TIMEOUT_CYCLES cycles -> cq error 1. Same-cycle scenario: matching status arrives exactly at timeout -> error follows status_error.
REQ-026 Backpressure scenario: hold dma_req_ready and cq_ready low for 10 cycles -> valid outputs and payloads stay stable and s_axis_wqe_ready stays 0. Mismatched status tag -> ignored, FSM remains in WAIT.
REQ-027 Wrap/reset scenario: 257 SEND WQEs -> tags wrap 255 -> 0. Reset asserted in WAIT -> all outputs 0 and no commit is produced.
